sequenciador_busca: RTL and testbench

//  Fetch/update sequencer for the 8-bit program counter (contador_de_programa).

---
 rtl/redux_pkg.sv | 16 +
 rtl/calc_proximo_pc.sv | 24 ++
 rtl/sequenciador_busca.sv | 156 +++++++++++++++
 tb/tb_sequenciador_busca.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/redux_pkg.sv
// Shared definitions for the fetch/update sequencer: state encoding and default PC width.
package redux_pkg;

    localparam int unsigned LARG_PC_PADRAO = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        FETCH  = 3'd2,
        EXEC   = 3'd3,
        UPDATE = 3'd4,
        HALT   = 3'd5,
        ERRO   = 3'd6
    } estado_t;

endpackage

// File: rtl/calc_proximo_pc.sv
// Combinational next-PC selection: absolute jump, relative branch or increment (modulo 2**LARG_PC).
module calc_proximo_pc
    import redux_pkg::*;
#(
    parameter int unsigned LARG_PC = LARG_PC_PADRAO
) (
    input  logic [LARG_PC-1:0] pc_atual,
    input  logic [LARG_PC-1:0] alvo,
    input  logic               desvio_tomado,
    input  logic               salto_abs,
    output logic [LARG_PC-1:0] pc_calc
);

    // Absolute jump wins over a taken branch; sums wrap silently.
    always_comb begin
        pc_calc = pc_atual + LARG_PC'(1);
        if (salto_abs) begin
            pc_calc = alvo;
        end else if (desvio_tomado) begin
            pc_calc = pc_atual + alvo;
        end
    end

endmodule

// File: rtl/sequenciador_busca.sv
// Fetch/update sequencer for the program counter: initialises the PC, handshakes fetches,
// waits for execution and writes the next PC. Optional macro SEQUENCIADOR_CONTA_INSTR_EN adds instr_count.
module sequenciador_busca
    import redux_pkg::*;
#(
    parameter int unsigned LARG_PC  = LARG_PC_PADRAO,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt_req,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic               exec_done,
    input  logic               desvio_tomado,
    input  logic               salto_abs,
    input  logic [LARG_PC-1:0] alvo,
    input  logic [LARG_PC-1:0] pc_atual,
    output logic [LARG_PC-1:0] pc_proximo,
    output logic               pc_we,
    output logic               parado,
    output logic               erro,
    output logic [2:0]         estado
`ifdef SEQUENCIADOR_CONTA_INSTR_EN
    ,
    output logic [15:0]        instr_count
`endif
);

    localparam int unsigned           LARG_CNT   = $clog2(TIMEOUT + 1);
    localparam logic [LARG_PC-1:0]    PC_INICIAL = LARG_PC'(RESET_PC);
    localparam logic [LARG_CNT-1:0]   CNT_LIMITE = LARG_CNT'(TIMEOUT - 1);

    estado_t               estado_q, estado_d;
    logic [LARG_CNT-1:0]   espera_q, espera_d;
    logic                  halt_pend_q, halt_pend_d;
    logic [LARG_PC-1:0]    pc_proximo_q, pc_proximo_d;
    logic [LARG_PC-1:0]    pc_calc;
    logic                  halt_amostra;
    logic                  imem_req_q, pc_we_q, parado_q, erro_q;

    calc_proximo_pc #(
        .LARG_PC(LARG_PC)
    ) u_calc (
        .pc_atual      (pc_atual),
        .alvo          (alvo),
        .desvio_tomado (desvio_tomado),
        .salto_abs     (salto_abs),
        .pc_calc       (pc_calc)
    );

    // A halt request raised in the UPDATE cycle itself still takes effect there.
    assign halt_amostra = halt_pend_q | halt_req;

    always_comb begin
        estado_d     = estado_q;
        espera_d     = '0;
        halt_pend_d  = halt_pend_q;
        pc_proximo_d = pc_proximo_q;
        unique case (estado_q)
            IDLE: begin
                if (start) begin
                    estado_d     = INIT;
                    pc_proximo_d = PC_INICIAL;
                end
            end
            INIT: begin
                halt_pend_d = halt_amostra;
                estado_d    = FETCH;
            end
            FETCH: begin
                halt_pend_d = halt_amostra;
                if (imem_ack) begin
                    estado_d = EXEC;
                end else if (espera_q == CNT_LIMITE) begin
                    estado_d = ERRO;
                end else begin
                    espera_d = espera_q + LARG_CNT'(1);
                end
            end
            EXEC: begin
                halt_pend_d = halt_amostra;
                if (exec_done) begin
                    estado_d     = UPDATE;
                    pc_proximo_d = pc_calc;
                end
            end
            UPDATE: begin
                if (halt_amostra) begin
                    estado_d    = HALT;
                    halt_pend_d = 1'b0;
                end else begin
                    estado_d    = FETCH;
                end
            end
            HALT: begin
                if (start && !halt_req) begin
                    estado_d = FETCH;
                end
            end
            ERRO: begin
                estado_d = ERRO;
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    // Outputs are flopped from the next state so they line up with estado_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= IDLE;
            espera_q     <= '0;
            halt_pend_q  <= 1'b0;
            pc_proximo_q <= PC_INICIAL;
            imem_req_q   <= 1'b0;
            pc_we_q      <= 1'b0;
            parado_q     <= 1'b0;
            erro_q       <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            espera_q     <= espera_d;
            halt_pend_q  <= halt_pend_d;
            pc_proximo_q <= pc_proximo_d;
            imem_req_q   <= (estado_d == FETCH);
            pc_we_q      <= (estado_d == INIT) || (estado_d == UPDATE);
            parado_q     <= (estado_d == HALT);
            erro_q       <= (estado_d == ERRO);
        end
    end

    assign imem_req   = imem_req_q;
    assign pc_we      = pc_we_q;
    assign parado     = parado_q;
    assign erro       = erro_q;
    assign pc_proximo = pc_proximo_q;
    assign estado     = estado_q;

`ifdef SEQUENCIADOR_CONTA_INSTR_EN
    logic [15:0] conta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conta_q <= '0;
        end else if (estado_q == UPDATE) begin
            conta_q <= conta_q + 16'd1;
        end
    end

    assign instr_count = conta_q;
`endif

endmodule

// File: tb/tb_sequenciador_busca.sv
// Self-checking bench for sequenciador_busca: directed and randomized instruction streams
// checked against a transaction-level model of the PC sequence.
module tb_sequenciador_busca;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, halt_req, imem_ack, exec_done, desvio_tomado, salto_abs;
    logic [7:0] alvo, pc_atual, pc_proximo;
    logic       imem_req, pc_we, parado, erro;
    logic [2:0] estado;
`ifdef SEQUENCIADOR_CONTA_INSTR_EN
    logic [15:0] instr_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int modelo_pc;
    int modelo_conta;
    logic [7:0] pc_reg;

    always #5 clk = ~clk;

    // Stand-in for contador_de_programa: no reset, written only by pc_we.
    always @(posedge clk) if (pc_we) pc_reg <= pc_proximo;
    assign pc_atual = pc_reg;

    sequenciador_busca dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .halt_req      (halt_req),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .exec_done     (exec_done),
        .desvio_tomado (desvio_tomado),
        .salto_abs     (salto_abs),
        .alvo          (alvo),
        .pc_atual      (pc_atual),
        .pc_proximo    (pc_proximo),
        .pc_we         (pc_we),
        .parado        (parado),
        .erro          (erro),
        .estado        (estado)
`ifdef SEQUENCIADOR_CONTA_INSTR_EN
        ,
        .instr_count   (instr_count)
`endif
    );

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    task automatic verifica_conta();
`ifdef SEQUENCIADOR_CONTA_INSTR_EN
        verifica("instr_count", instr_count, modelo_conta[15:0]);
`endif
    endtask

    // Runs one instruction starting at a negedge in FETCH; ends at the negedge after UPDATE.
    task automatic instr(input int d_ack, input int d_exec, input logic desv, input logic salt,
                         input logic [7:0] al, input logic pede_halt);
        int esperado;
        verifica("req_inicio", imem_req, 1);
        verifica("pc_atual", pc_atual, modelo_pc);
        if (pede_halt) halt_req = 1'b1;
        for (int i = 0; i < d_ack; i++) begin
            @(negedge clk);
            halt_req = 1'b0;
            verifica("req_espera", imem_req, 1);
        end
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        halt_req = 1'b0;
        verifica("req_baixa", imem_req, 0);
        verifica("we_exec", pc_we, 0);
        for (int i = 0; i < d_exec; i++) begin
            // Branch inputs are garbage until exec_done.
            desvio_tomado = 1'($urandom);
            salto_abs     = 1'($urandom);
            alvo          = 8'($urandom);
            @(negedge clk);
            verifica("we_exec", pc_we, 0);
        end
        if (salt)      esperado = al;
        else if (desv) esperado = (modelo_pc + al) % 256;
        else           esperado = (modelo_pc + 1) % 256;
        exec_done = 1'b1;
        desvio_tomado = desv;
        salto_abs = salt;
        alvo = al;
        @(negedge clk);
        exec_done = 1'b0;
        desvio_tomado = 1'b0;
        salto_abs = 1'b0;
        verifica("we_update", pc_we, 1);
        verifica("pc_proximo", pc_proximo, esperado);
        modelo_pc = esperado;
        modelo_conta++;
        @(negedge clk);
        verifica("we_pulso", pc_we, 0);
        verifica("parado", parado, pede_halt);
        if (pede_halt) verifica("req_halt", imem_req, 0);
    endtask

    // In HALT: a start masked by halt_req must not resume; a clean start must.
    task automatic retoma();
        @(negedge clk);
        verifica("halt_fica", parado, 1);
        start = 1'b1;
        halt_req = 1'b1;
        @(negedge clk);
        start = 1'b0;
        halt_req = 1'b0;
        verifica("halt_prioridade", parado, 1);
        verifica_conta();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        verifica("retoma_parado", parado, 0);
        verifica("retoma_we", pc_we, 0);
    endtask

    task automatic reset_e_init();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        verifica("init_we", pc_we, 1);
        verifica("init_pc", pc_proximo, 0);
        verifica("init_estado", estado, 1);
        modelo_pc = 0;
        modelo_conta = 0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic ph;
        rst_n = 1'b0;
        {start, halt_req, imem_ack, exec_done, desvio_tomado, salto_abs} = '0;
        alvo = '0;
        modelo_pc = 0;
        modelo_conta = 0;
        @(negedge clk);
        @(negedge clk);
        verifica("rst_req", imem_req, 0);
        verifica("rst_we", pc_we, 0);
        verifica("rst_pc", pc_proximo, 0);
        verifica("rst_parado", parado, 0);
        verifica("rst_erro", erro, 0);
        verifica("rst_estado", estado, 0);
        verifica_conta();
        rst_n = 1'b1;
        @(negedge clk);
        verifica("idle_fica", estado, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        verifica("init_we", pc_we, 1);
        verifica("init_pc", pc_proximo, 0);
        @(negedge clk);

        // Back-to-back sequential instructions: writes 1, 2, 3 every third cycle.
        for (int i = 0; i < 3; i++) instr(0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
        // Branch arithmetic and wrap-around.
        instr(1, 0, 1'b0, 1'b1, 8'h0A, 1'b0);
        instr(0, 1, 1'b1, 1'b0, 8'hFC, 1'b0);
        verifica("pc_desvio", modelo_pc, 6);
        instr(0, 0, 1'b1, 1'b1, 8'h40, 1'b0);
        instr(0, 0, 1'b0, 1'b1, 8'hFF, 1'b0);
        instr(0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
        verifica("wrap_erro", erro, 0);
        // Halt requested mid-FETCH.
        instr(2, 1, 1'b0, 1'b0, 8'h00, 1'b1);
        retoma();

        for (int k = 0; k < 40; k++) begin
            ph = ($urandom_range(0, 7) == 0);
            instr($urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom),
                  ($urandom_range(0, 3) == 0), 8'($urandom), ph);
            if (ph) retoma();
        end
        verifica_conta();

        // Fetch timeout: imem_ack never arrives.
        n = 0;
        while (imem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        verifica("timeout_ciclos", n, 15);
        verifica("timeout_erro", erro, 1);
        verifica("timeout_estado", estado, 6);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        verifica("erro_preso", erro, 1);
        verifica("erro_req", imem_req, 0);
        verifica("erro_estado", estado, 6);
        verifica_conta();
        rst_n = 1'b0;
        #1;
        verifica("erro_rst", erro, 0);
        verifica("erro_rst_estado", estado, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while exec_done is being presented: the pending write is dropped.
        reset_e_init();
        modelo_pc = 0;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        verifica("exec_estado", estado, 3);
        exec_done = 1'b1;
        rst_n = 1'b0;
        #1;
        verifica("rst_exec_we", pc_we, 0);
        verifica("rst_exec_pc", pc_proximo, 0);
        verifica("rst_exec_estado", estado, 0);
        modelo_conta = 0;
        verifica_conta();
        @(posedge clk);
        #1;
        verifica("rst_exec_we_borda", pc_we, 0);
        @(negedge clk);
        exec_done = 1'b0;
        reset_e_init();
        instr(0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
        verifica_conta();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
